display_timing: RTL and testbench
=================================

Name: display_timing

Overview:
- Parametrised successor to the fixed 480p timing generator: a generic signed-coordinate video timing generator for any resolution and porch set.
- Produces hsync, vsync and de, frame/line strobes, a free-running frame counter, and a runtime-programmable line-compare interrupt.
- Sync and control outputs can be delayed by CTRL_DLY cycles relative to sx/sy. This lets the downstream renderer pipeline compute a pixel from sx/sy and present it aligned with de and the syncs.
- Sits between the pixel-clock domain reset logic and the game renderer/video output.

Parameters:
CORDW, 16, signed coordinate width; must represent H_STA, V_STA, H_RES-1 and V_RES-1
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low, 1 = active-high)
V_POL, 0, vsync active level
CTRL_DLY, 0, extra delay (0..15 cycles) on hsync/vsync/de/frame/line relative to sx/sy
FCW, 16, frame counter width

Ports:
clk_pix  in  1  pixel clock; the only clock
rst_pix  in  1  reset, synchronous, active-high
line_cmp  in  CORDW  signed line number for line_irq; sampled every cycle
hsync  out  1  horizontal sync at H_POL level
vsync  out  1  vertical sync at V_POL level
de  out  1  data enable; high only for active pixels
frame  out  1  1-cycle strobe at first pixel of frame (H_STA,V_STA)
line  out  1  1-cycle strobe at start (x=H_STA) of every active line
line_irq  out  1  1-cycle strobe at x=H_STA of line y==line_cmp
sx  out  CORDW  signed horizontal position
sy  out  CORDW  signed vertical position
frame_cnt  out  FCW  completed-frame counter

Behaviour:
- Derived constants:
  - H_STA = -(H_FP+H_SYNC+H_BP); HS_STA = H_STA+H_FP; HS_END = HS_STA+H_SYNC.
  - V_STA = -(V_FP+V_SYNC+V_BP); VS_STA = V_STA+V_FP; VS_END = VS_STA+V_SYNC.
  - Active region is x,y >= 0.
- Internal counters x and y (signed CORDW):
  - x increments each cycle. At x==H_RES-1, x <= H_STA and y advances.
  - y wraps from V_RES-1 to V_STA. Note: V_STA, not 0.
  - Line period = H_FP+H_SYNC+H_BP+H_RES cycles. Frame period = line period × (V_FP+V_SYNC+V_BP+V_RES).
- Sync active windows are half-open: hsync is active for HS_STA <= x < HS_END, vsync for VS_STA <= y < VS_END. vsync changes together with x wrap.
- Stage 1 (latency 1 from counters), all registered:
  - sx <= x; sy <= y.
  - de_r = (x>=0 && y>=0).
  - frame_r = (x==H_STA && y==V_STA).
  - line_r = (x==H_STA && y>=0).
  - line_irq = (x==H_STA && y==line_cmp).
  - hs_r, vs_r = window tests XNOR-polarised per H_POL/V_POL.
- Delay line: hs_r, vs_r, de_r, frame_r and line_r pass through a CTRL_DLY-deep shift register to hsync, vsync, de, frame and line. With CTRL_DLY=0 they come straight from stage 1.
- sx, sy, line_irq and frame_cnt are not delayed.
- frame_cnt:
  - Increments (mod 2^FCW) on the cycle sx/sy become (H_STA,V_STA), except the first such occurrence after reset.
  - It therefore holds the number of fully completed frames.
  - Wraps silently.
- line_cmp outside [V_STA,V_RES-1]: line_irq never asserts. Changing line_cmp mid-frame takes effect at the next line start.
- Reset:
  - Takes effect on the clock edge where rst_pix=1. x=H_STA, y=V_STA.
  - Outputs: sx=H_STA, sy=V_STA, de=0, frame=0, line=0, line_irq=0, frame_cnt=0, first-frame flag set.
  - hsync=~H_POL, vsync=~V_POL (inactive). Every delay-line stage is loaded with these inactive values.
  - Reset mid-line or mid-frame aborts immediately. There is no partial strobe.
- After reset release:
  - First cycle: sx=H_STA, sy=V_STA, frame_r=0.
  - Second cycle: frame_r=1, since the counter was at (H_STA,V_STA) in the prior cycle. Frame strobe then repeats once per frame period.

Test Plan:
- Defaults, CTRL_DLY=0: release reset -> sx=-160, sy=-45, frame pulses once, then every 420000 cycles; exactly 307200 de-high cycles per frame.
- H_RES=8,H_FP=1,H_SYNC=2,H_BP=1,V_RES=4,V_FP=1,V_SYNC=1,V_BP=1 -> line=12 cycles, frame=84; hsync low only at sx=-3,-2; vsync low only for the 12 cycles with sy=-2; de high 8 cycles × 4 lines; line pulses at sx=-4, sy=0..3.
- Same timing, CTRL_DLY=3, H_POL=1 -> de rises exactly 3 cycles after sx first shows 0; hsync high (active) 2 cycles, starting 3 cycles after sx=-3; sx/sy unchanged vs CTRL_DLY=0.
- line_cmp=2 -> single line_irq per frame at sx=-4,sy=2; line_cmp=-3 -> pulse coincident with frame_r; line_cmp=10 -> no pulse over 3 frames.
- FCW=2 -> frame_cnt reads 0 during frame 1, then 1,2,3,0 at successive frame boundaries.
- rst_pix high 1 cycle while sx=5,sy=1, CTRL_DLY=2 -> next cycle de=0, hsync/vsync inactive, sx=-4, sy=-3, frame_cnt=0; no spurious de/line from delay line; normal frame resumes.

Source files
------------

// File: rtl/display_timing.sv
// Signed-coordinate video timing generator: hsync/vsync/de, frame/line strobes, line-compare irq, frame counter.
// sx/sy/line_irq/frame_cnt lag the counters by 1 cycle; syncs/de/strobes by 1+CTRL_DLY cycles. No backpressure.
module display_timing #(
    parameter int CORDW    = 16,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CTRL_DLY = 0,
    parameter int FCW      = 16
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic signed [CORDW-1:0] line_cmp,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line,
    output logic                    line_irq,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic [FCW-1:0]          frame_cnt
);

    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-(H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(-H_BP);
    localparam logic signed [CORDW-1:0] H_LAST = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-(V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(-V_BP);
    localparam logic signed [CORDW-1:0] V_LAST = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);
    // Control bundle order: {hsync, vsync, de, frame, line}
    localparam logic [4:0] CTL_OFF = {~HS_ON, ~VS_ON, 3'b000};

    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic                    first_frame;
    logic [4:0]              ctl_s1;
    logic [4:0]              ctl_out;
    logic                    hs_win;
    logic                    vs_win;
    logic                    at_hsta;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            x <= H_STA;
            y <= V_STA;
        end else if (x == H_LAST) begin
            x <= H_STA;
            y <= (y == V_LAST) ? V_STA : y + ONE;
        end else begin
            x <= x + ONE;
        end
    end

    assign hs_win  = (x >= HS_STA) && (x < HS_END);
    assign vs_win  = (y >= VS_STA) && (y < VS_END);
    assign at_hsta = (x == H_STA);

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sx          <= H_STA;
            sy          <= V_STA;
            ctl_s1      <= CTL_OFF;
            line_irq    <= 1'b0;
            frame_cnt   <= '0;
            first_frame <= 1'b1;
        end else begin
            sx       <= x;
            sy       <= y;
            ctl_s1   <= {hs_win ~^ HS_ON,
                         vs_win ~^ VS_ON,
                         ~x[CORDW-1] & ~y[CORDW-1],
                         at_hsta & (y == V_STA),
                         at_hsta & ~y[CORDW-1]};
            line_irq <= at_hsta & (y == line_cmp);
            // The frame start seen straight out of reset is not a completed frame.
            if (at_hsta && (y == V_STA)) begin
                if (first_frame) begin
                    first_frame <= 1'b0;
                end else begin
                    frame_cnt <= frame_cnt + FCW'(1);
                end
            end
        end
    end

    generate
        if (CTRL_DLY == 0) begin : g_nodly
            assign ctl_out = ctl_s1;
        end else begin : g_dly
            logic [4:0] pipe [CTRL_DLY];
            always_ff @(posedge clk_pix) begin
                if (rst_pix) begin
                    for (int i = 0; i < CTRL_DLY; i++) pipe[i] <= CTL_OFF;
                end else begin
                    pipe[0] <= ctl_s1;
                    for (int i = 1; i < CTRL_DLY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign ctl_out = pipe[CTRL_DLY-1];
        end
    endgenerate

    assign {hsync, vsync, de, frame, line} = ctl_out;

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing: four configurations run side by side against a cycle-count reference model.
module tb_display_timing;

    typedef struct {
        int hr, vr, hfp, hsw, hbp, vfp, vsw, vbp;
        bit hpol, vpol;
        int dly, fcw;
    } cfg_t;

    typedef struct {
        int sx, sy;
        bit hs, vs, de, fr, ln, irq;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst    [4];
    logic signed [15:0] cmp   [4];
    logic              hs_o   [4];
    logic              vs_o   [4];
    logic              de_o   [4];
    logic              fr_o   [4];
    logic              ln_o   [4];
    logic              irq_o  [4];
    logic signed [15:0] sx_o  [4];
    logic signed [15:0] sy_o  [4];
    logic [15:0]       fc0, fc2, fc3;
    logic [1:0]        fc1;

    cfg_t  cfg   [4];
    int    tcnt  [4];
    int    cmp_e [4];
    string nm    [4];
    int    n_checks = 0;
    int    n_errors = 0;

    display_timing u_def (
        .clk_pix(clk), .rst_pix(rst[0]), .line_cmp(cmp[0]),
        .hsync(hs_o[0]), .vsync(vs_o[0]), .de(de_o[0]), .frame(fr_o[0]), .line(ln_o[0]),
        .line_irq(irq_o[0]), .sx(sx_o[0]), .sy(sy_o[0]), .frame_cnt(fc0)
    );

    display_timing #(.H_RES(8), .V_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_FP(1), .V_SYNC(1),
                     .V_BP(1), .H_POL(0), .V_POL(0), .CTRL_DLY(0), .FCW(2)) u_a (
        .clk_pix(clk), .rst_pix(rst[1]), .line_cmp(cmp[1]),
        .hsync(hs_o[1]), .vsync(vs_o[1]), .de(de_o[1]), .frame(fr_o[1]), .line(ln_o[1]),
        .line_irq(irq_o[1]), .sx(sx_o[1]), .sy(sy_o[1]), .frame_cnt(fc1)
    );

    display_timing #(.H_RES(8), .V_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_FP(1), .V_SYNC(1),
                     .V_BP(1), .H_POL(1), .V_POL(0), .CTRL_DLY(3), .FCW(16)) u_b (
        .clk_pix(clk), .rst_pix(rst[2]), .line_cmp(cmp[2]),
        .hsync(hs_o[2]), .vsync(vs_o[2]), .de(de_o[2]), .frame(fr_o[2]), .line(ln_o[2]),
        .line_irq(irq_o[2]), .sx(sx_o[2]), .sy(sy_o[2]), .frame_cnt(fc2)
    );

    display_timing #(.H_RES(8), .V_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_FP(1), .V_SYNC(1),
                     .V_BP(1), .H_POL(0), .V_POL(0), .CTRL_DLY(2), .FCW(16)) u_c (
        .clk_pix(clk), .rst_pix(rst[3]), .line_cmp(cmp[3]),
        .hsync(hs_o[3]), .vsync(vs_o[3]), .de(de_o[3]), .frame(fr_o[3]), .line(ln_o[3]),
        .line_irq(irq_o[3]), .sx(sx_o[3]), .sy(sy_o[3]), .frame_cnt(fc3)
    );

    // Expected outputs after t clock edges since the last reset edge (t=0 is the reset edge itself).
    function automatic exp_t model(cfg_t c, int t, int cmpv);
        exp_t e;
        int ll, fl, hsta, vsta, q, x, y, td;
        ll   = c.hfp + c.hsw + c.hbp + c.hr;
        fl   = ll * (c.vfp + c.vsw + c.vbp + c.vr);
        hsta = -(c.hfp + c.hsw + c.hbp);
        vsta = -(c.vfp + c.vsw + c.vbp);
        if (t == 0) begin
            e.sx  = hsta;
            e.sy  = vsta;
            e.irq = 1'b0;
            e.fc  = 0;
        end else begin
            q     = (t - 1) % fl;
            e.sx  = hsta + q % ll;
            e.sy  = vsta + q / ll;
            e.irq = (e.sx == hsta) && (e.sy == cmpv);
            e.fc  = ((t - 1) / fl) % (1 << c.fcw);
        end
        td = t - c.dly;
        if (td < 1) begin
            e.hs = !c.hpol;
            e.vs = !c.vpol;
            e.de = 1'b0;
            e.fr = 1'b0;
            e.ln = 1'b0;
        end else begin
            q    = (td - 1) % fl;
            x    = hsta + q % ll;
            y    = vsta + q / ll;
            e.hs = (x >= hsta + c.hfp && x < hsta + c.hfp + c.hsw) ? c.hpol : !c.hpol;
            e.vs = (y >= vsta + c.vfp && y < vsta + c.vfp + c.vsw) ? c.vpol : !c.vpol;
            e.de = (x >= 0) && (y >= 0);
            e.fr = (q == 0);
            e.ln = (x == hsta) && (y >= 0);
        end
        return e;
    endfunction

    task automatic check(string tag, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s @%0t got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic compare(int i);
        exp_t e;
        int   fc_got;
        e = model(cfg[i], tcnt[i], cmp_e[i]);
        case (i)
            0:       fc_got = int'(fc0);
            1:       fc_got = int'(fc1);
            2:       fc_got = int'(fc2);
            default: fc_got = int'(fc3);
        endcase
        check({nm[i], ".sx"},        int'(sx_o[i]),  e.sx);
        check({nm[i], ".sy"},        int'(sy_o[i]),  e.sy);
        check({nm[i], ".hsync"},     int'(hs_o[i]),  int'(e.hs));
        check({nm[i], ".vsync"},     int'(vs_o[i]),  int'(e.vs));
        check({nm[i], ".de"},        int'(de_o[i]),  int'(e.de));
        check({nm[i], ".frame"},     int'(fr_o[i]),  int'(e.fr));
        check({nm[i], ".line"},      int'(ln_o[i]),  int'(e.ln));
        check({nm[i], ".line_irq"},  int'(irq_o[i]), int'(e.irq));
        check({nm[i], ".frame_cnt"}, fc_got,         e.fc);
    endtask

    bit seen_a = 1'b0;
    int per_cnt = 0, de_cnt = 0, ln_cnt = 0;

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rst[i]) tcnt[i] = 0;
            else        tcnt[i]++;
            cmp_e[i] = int'(cmp[i]);
        end
        #1;
        for (int i = 0; i < 4; i++) compare(i);
        // Whole-frame totals for the small unresettable instance
        if (fr_o[1]) begin
            if (seen_a) begin
                check("a.frame_period",    per_cnt, 84);
                check("a.de_per_frame",    de_cnt,  32);
                check("a.lines_per_frame", ln_cnt,  4);
            end
            seen_a  = 1'b1;
            per_cnt = 0;
            de_cnt  = 0;
            ln_cnt  = 0;
        end
        per_cnt++;
        de_cnt += int'(de_o[1]);
        ln_cnt += int'(ln_o[1]);
    endtask

    function automatic logic signed [15:0] rnd_cmp(int lo, int span);
        return 16'(lo + int'($urandom_range(span)));
    endfunction

    initial begin
        bit done_c = 1'b0;
        cfg[0] = '{hr:640, vr:480, hfp:16, hsw:96, hbp:48, vfp:10, vsw:2, vbp:33,
                   hpol:1'b0, vpol:1'b0, dly:0, fcw:16};
        cfg[1] = '{hr:8, vr:4, hfp:1, hsw:2, hbp:1, vfp:1, vsw:1, vbp:1,
                   hpol:1'b0, vpol:1'b0, dly:0, fcw:2};
        cfg[2] = '{hr:8, vr:4, hfp:1, hsw:2, hbp:1, vfp:1, vsw:1, vbp:1,
                   hpol:1'b1, vpol:1'b0, dly:3, fcw:16};
        cfg[3] = '{hr:8, vr:4, hfp:1, hsw:2, hbp:1, vfp:1, vsw:1, vbp:1,
                   hpol:1'b0, vpol:1'b0, dly:2, fcw:16};
        nm[0] = "def"; nm[1] = "a"; nm[2] = "b"; nm[3] = "c";
        for (int i = 0; i < 4; i++) begin
            rst[i]   = 1'b1;
            tcnt[i]  = 0;
            cmp_e[i] = 0;
        end
        cmp[0] = 16'sd100;
        cmp[1] = 16'sd2;
        cmp[2] = 16'sd1;
        cmp[3] = -16'sd3;

        repeat (3) step();
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;

        // Directed: line_cmp 2, -3, then out of range, three frames each on the small instance
        for (int n = 0; n < 9 * 84; n++) begin
            step();
            if (n == 3 * 84) cmp[1] = -16'sd3;
            if (n == 6 * 84) cmp[1] = 16'sd10;
            if ($urandom_range(49) == 0) cmp[2] = rnd_cmp(-5, 11);
            if (!done_c && sx_o[3] == 16'sd5 && sy_o[3] == 16'sd1) begin
                rst[3] = 1'b1;
                done_c = 1'b1;
            end else begin
                rst[3] = 1'b0;
            end
        end
        check("c.mid_reset_hit", int'(done_c), 1);

        // Random line_cmp changes and random reset pulses
        for (int n = 0; n < 3000; n++) begin
            step();
            if ($urandom_range(29) == 0) cmp[1] = rnd_cmp(-5, 11);
            if ($urandom_range(29) == 0) cmp[2] = rnd_cmp(-5, 11);
            if ($urandom_range(29) == 0) cmp[3] = rnd_cmp(-5, 11);
            if ($urandom_range(99) == 0) cmp[0] = rnd_cmp(-50, 100);
            rst[0] = ($urandom_range(999) == 0);
            rst[2] = ($urandom_range(199) == 0);
            rst[3] = ($urandom_range(199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
